// File: rtl/sync_pulse_checker_pkg.sv
// Shared types and default sizing for sync_pulse_checker.
// Build option: SYNC_PULSE_CHECKER_2FF_EN selects the two-flop synchronizer input path.
package sync_pulse_checker_pkg;

    localparam int GAP_W_DEF   = 8;
    localparam int MIN_GAP_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SAT
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, both stages cleared by a synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sync_pulse_checker.sv
// Rising-edge detector and edge-spacing checker for the skew-stage sync output.
// Define SYNC_PULSE_CHECKER_2FF_EN to insert a two-flop synchronizer on sync_in.
module sync_pulse_checker
    import sync_pulse_checker_pkg::*;
#(
    parameter int GAP_W   = GAP_W_DEF,
    parameter int MIN_GAP = MIN_GAP_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    input  logic             clear,
    output logic             edge_pulse,
    output logic [GAP_W-1:0] gap,
    output logic             gap_valid,
    output logic             viol,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam logic [GAP_W-1:0] GAP_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    logic             s;
    logic             s_d;
    logic             rise;
    logic [GAP_W-1:0] counter;
    state_t           state;

`ifdef SYNC_PULSE_CHECKER_2FF_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sync_in),
        .q   (s)
    );
`else
    // Zero-delay runs only: sync_in is sampled by a single flop.
    always_ff @(posedge clk) begin
        if (rst) s <= 1'b0;
        else     s <= sync_in;
    end
`endif

    assign rise = s & ~s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d        <= 1'b0;
            state      <= IDLE;
            counter    <= '0;
            edge_pulse <= 1'b0;
            gap        <= '0;
            gap_valid  <= 1'b0;
            viol       <= 1'b0;
        end else begin
            s_d        <= s;
            edge_pulse <= 1'b0;
            gap_valid  <= 1'b0;
            viol       <= 1'b0;
            case (state)
                IDLE: begin
                    // First edge has no predecessor, so no spacing is reported.
                    if (rise) begin
                        edge_pulse <= 1'b1;
                        counter    <= GAP_ONE;
                        state      <= COUNT;
                    end
                end
                COUNT, SAT: begin
                    if (rise) begin
                        edge_pulse <= 1'b1;
                        gap        <= counter;
                        gap_valid  <= 1'b1;
                        viol       <= (counter < GAP_MIN);
                        counter    <= GAP_ONE;
                        state      <= COUNT;
                    end else if (state == COUNT) begin
                        counter <= counter + GAP_ONE;
                        if (counter == GAP_MAX - GAP_ONE) state <= SAT;
                    end
                end
                default: begin
                    counter <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Counts the registered viol strobe; clear wins but keeps a same-cycle violation.
    always_ff @(posedge clk) begin
        if (rst)                       viol_cnt <= '0;
        else if (clear)                viol_cnt <= viol ? CNT_W'(1) : '0;
        else if (viol && viol_cnt != CNT_MAX) viol_cnt <= viol_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_sync_pulse_checker.sv
// Directed self-checking bench for sync_pulse_checker (GAP_W=8, MIN_GAP=4, CNT_W=16).
module tb_sync_pulse_checker;
    import sync_pulse_checker_pkg::*;

`ifdef SYNC_PULSE_CHECKER_2FF_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        sync_in;
    logic        clear;
    logic        edge_pulse;
    logic [7:0]  gap;
    logic        gap_valid;
    logic        viol;
    logic [15:0] viol_cnt;

    int vectors;
    int miscompares;

    sync_pulse_checker #(.GAP_W(8), .MIN_GAP(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .clear      (clear),
        .edge_pulse (edge_pulse),
        .gap        (gap),
        .gap_valid  (gap_valid),
        .viol       (viol),
        .viol_cnt   (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Two one-sample highs on sync_in, k edges apart; returns at the second edge_pulse.
    task automatic pair(input int k);
        sync_in = 1'b1; cyc(); sync_in = 1'b0;
        repeat (k - 1) cyc();
        sync_in = 1'b1; cyc(); sync_in = 1'b0;
        repeat (LAT - 1) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; sync_in = 1'b0; clear = 1'b0;
        repeat (3) cyc();
        vectors++; if ({edge_pulse, gap_valid, viol} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes got=%b exp=000", {edge_pulse, gap_valid, viol}); end
        vectors++; if (gap !== 8'd0) begin miscompares++; $display("FAIL reset_gap got=%0d exp=0", gap); end
        vectors++; if (viol_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_viol_cnt got=%0d exp=0", viol_cnt); end
        vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            vectors++; if ({edge_pulse, gap_valid, viol} !== 3'b000) begin miscompares++; $display("FAIL idle_strobes cycle=%0d got=%b exp=000", i, {edge_pulse, gap_valid, viol}); end
        end
    endtask

    task automatic test_single_edge();
        sync_in = 1'b1; cyc(); sync_in = 1'b0;
        repeat (LAT - 2) cyc();
        vectors++; if (edge_pulse !== 1'b0) begin miscompares++; $display("FAIL single_early got=%b exp=0", edge_pulse); end
        cyc();
        vectors++; if (edge_pulse !== 1'b1) begin miscompares++; $display("FAIL single_edge_pulse got=%b exp=1", edge_pulse); end
        vectors++; if (gap_valid !== 1'b0) begin miscompares++; $display("FAIL single_gap_valid got=%b exp=0", gap_valid); end
        vectors++; if (gap !== 8'd0) begin miscompares++; $display("FAIL single_gap got=%0d exp=0", gap); end
        cyc();
        vectors++; if (edge_pulse !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle got=%b exp=0", edge_pulse); end
    endtask

    task automatic test_gap_10();
        repeat (10) cyc();
        pair(10);
        vectors++; if (edge_pulse !== 1'b1) begin miscompares++; $display("FAIL gap10_edge_pulse got=%b exp=1", edge_pulse); end
        vectors++; if (gap !== 8'd10) begin miscompares++; $display("FAIL gap10_gap got=%0d exp=10", gap); end
        vectors++; if (gap_valid !== 1'b1) begin miscompares++; $display("FAIL gap10_gap_valid got=%b exp=1", gap_valid); end
        vectors++; if (viol !== 1'b0) begin miscompares++; $display("FAIL gap10_viol got=%b exp=0", viol); end
        cyc();
        vectors++; if (viol_cnt !== 16'd0) begin miscompares++; $display("FAIL gap10_viol_cnt got=%0d exp=0", viol_cnt); end
        vectors++; if ({gap_valid, gap} !== {1'b0, 8'd10}) begin miscompares++; $display("FAIL gap10_hold got=%b/%0d exp=0/10", gap_valid, gap); end
    endtask

    task automatic test_violation();
        repeat (10) cyc();
        pair(3);
        vectors++; if (gap !== 8'd3) begin miscompares++; $display("FAIL viol_gap got=%0d exp=3", gap); end
        vectors++; if (viol !== 1'b1) begin miscompares++; $display("FAIL viol_strobe got=%b exp=1", viol); end
        vectors++; if (viol_cnt !== 16'd0) begin miscompares++; $display("FAIL viol_cnt_latency got=%0d exp=0", viol_cnt); end
        cyc();
        vectors++; if (viol_cnt !== 16'd1) begin miscompares++; $display("FAIL viol_cnt_first got=%0d exp=1", viol_cnt); end
        vectors++; if (viol !== 1'b0) begin miscompares++; $display("FAIL viol_one_cycle got=%b exp=0", viol); end
        repeat (10) cyc();
        pair(3);
        cyc();
        vectors++; if (viol_cnt !== 16'd2) begin miscompares++; $display("FAIL viol_cnt_second got=%0d exp=2", viol_cnt); end
    endtask

    task automatic test_back_to_back();
        repeat (10) cyc();
        pair(2);
        vectors++; if ({gap_valid, gap} !== {1'b1, 8'd2}) begin miscompares++; $display("FAIL b2b_gap got=%b/%0d exp=1/2", gap_valid, gap); end
        vectors++; if (viol !== 1'b1) begin miscompares++; $display("FAIL b2b_viol got=%b exp=1", viol); end
        cyc();
        vectors++; if (viol_cnt !== 16'd3) begin miscompares++; $display("FAIL b2b_viol_cnt got=%0d exp=3", viol_cnt); end
    endtask

    task automatic test_saturation();
        repeat (10) cyc();
        sync_in = 1'b1; cyc(); sync_in = 1'b0;
        repeat (299) cyc();
        vectors++; if (dut.state !== SAT) begin miscompares++; $display("FAIL sat_state got=%0d exp=%0d", dut.state, SAT); end
        sync_in = 1'b1; cyc(); sync_in = 1'b0;
        repeat (LAT - 1) cyc();
        vectors++; if ({gap_valid, gap} !== {1'b1, 8'd255}) begin miscompares++; $display("FAIL sat_gap got=%b/%0d exp=1/255", gap_valid, gap); end
        vectors++; if (viol !== 1'b0) begin miscompares++; $display("FAIL sat_viol got=%b exp=0", viol); end
        vectors++; if (dut.state !== COUNT) begin miscompares++; $display("FAIL sat_exit got=%0d exp=%0d", dut.state, COUNT); end
    endtask

    task automatic test_clear();
        clear = 1'b1; cyc(); clear = 1'b0;
        vectors++; if (viol_cnt !== 16'd0) begin miscompares++; $display("FAIL clear_idle got=%0d exp=0", viol_cnt); end
        repeat (10) cyc();
        pair(3);
        cyc();
        vectors++; if (viol_cnt !== 16'd1) begin miscompares++; $display("FAIL clear_prep got=%0d exp=1", viol_cnt); end
        repeat (10) cyc();
        pair(3);
        vectors++; if (viol !== 1'b1) begin miscompares++; $display("FAIL clear_viol got=%b exp=1", viol); end
        clear = 1'b1; cyc(); clear = 1'b0;
        vectors++; if (viol_cnt !== 16'd1) begin miscompares++; $display("FAIL clear_with_viol got=%0d exp=1", viol_cnt); end
    endtask

    task automatic test_reset_mid();
        repeat (10) cyc();
        sync_in = 1'b1; cyc(); sync_in = 1'b0;
        repeat (LAT - 1) cyc();
        vectors++; if (edge_pulse !== 1'b1) begin miscompares++; $display("FAIL mid_first_edge got=%b exp=1", edge_pulse); end
        repeat (5) cyc();
        rst = 1'b1; cyc();
        vectors++; if ({edge_pulse, gap_valid, viol, gap, viol_cnt} !== 27'd0) begin miscompares++; $display("FAIL mid_reset_outputs got=%b/%b/%b/%0d/%0d exp=all 0", edge_pulse, gap_valid, viol, gap, viol_cnt); end
        rst = 1'b0;
        sync_in = 1'b1; cyc(); sync_in = 1'b0;
        repeat (LAT - 1) cyc();
        vectors++; if ({edge_pulse, gap_valid} !== 2'b10) begin miscompares++; $display("FAIL mid_after_reset got=%b exp=10", {edge_pulse, gap_valid}); end
    endtask

    task automatic test_high_at_release();
        rst = 1'b1; sync_in = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        repeat (LAT - 1) cyc();
        vectors++; if ({edge_pulse, gap_valid} !== 2'b10) begin miscompares++; $display("FAIL release_high_edge got=%b exp=10", {edge_pulse, gap_valid}); end
        cyc();
        vectors++; if (edge_pulse !== 1'b0) begin miscompares++; $display("FAIL release_high_steady got=%b exp=0", edge_pulse); end
        sync_in = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; sync_in = 1'b0; clear = 1'b0;
        test_reset();
        test_single_edge();
        test_gap_10();
        test_violation();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_reset_mid();
        test_high_at_release();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_pulse_checker.md
# sync_pulse_checker

Single-clock consumer of the `sync` output of the clock-skew stage, sitting directly downstream of it in the gate-level study flow. It brings `sync` into its own clock domain and detects rising edges. It measures the spacing between consecutive edges in clock cycles and flags spacings shorter than a programmable minimum. The bench and SDF-annotated runs use it to turn timing-check behaviour into countable, checkable events.

## Interface
- `GAP_W`, 8: width of the edge-spacing counter and the `gap` output.
- `MIN_GAP`, 4: smallest legal edge spacing in cycles; legal range is 2 .. 2^GAP_W−1.
- `CNT_W`, 16: width of the violation counter.

- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `sync_in`  in  1  `sync` from the skew stage; asynchronous to `clk`.
- `clear`  in  1  synchronous clear of `viol_cnt`.
- `edge_pulse`  out  1  one-cycle strobe per detected rising edge.
- `gap`  out  GAP_W  cycles between the last two edges; held between updates.
- `gap_valid`  out  1  one-cycle strobe, `gap` updated this cycle.
- `viol`  out  1  one-cycle strobe, `gap` < MIN_GAP.
- `viol_cnt`  out  CNT_W  saturating count of `viol` strobes.

## Operation
- Input path:
  - Synchronizer (see Configuration) output `s`.
  - Delayed copy `s_d`.
  - Internal edge signal `rise = s & ~s_d`.
- FSM states:
  - IDLE: no edge since reset.
  - COUNT: spacing counter running.
  - SAT: counter at 2^GAP_W−1.
- IDLE:
  - On `rise`: `edge_pulse`=1, counter:=1, go to COUNT.
  - No `gap_valid` is produced, because there is no previous edge.
- COUNT:
  - Counter increments by 1 each cycle.
  - When the counter reaches 2^GAP_W−1, go to SAT.
- SAT: counter holds at 2^GAP_W−1.
- On `rise` in COUNT or SAT:
  - `edge_pulse`=1, `gap`:=counter, `gap_valid`=1.
  - `viol`=(counter < MIN_GAP).
  - Counter:=1, go to or stay in COUNT.
- Resulting `gap` value: equals the number of cycles between the two `edge_pulse` assertions, saturating at 2^GAP_W−1.
- `viol_cnt`:
  - Increments on `viol` and saturates at 2^CNT_W−1.
  - `clear` has priority: the next value is 1 if `viol` is asserted that cycle, else 0.
- Reset behaviour:
  - Every output is 0: `edge_pulse`, `gap`, `gap_valid`, `viol`, `viol_cnt`.
  - FSM returns to IDLE; counter, synchronizer and `s_d` are all 0.
  - Reset mid-operation discards any spacing in progress; the first edge after reset never produces `gap_valid`.
- `sync_in` already high at reset release counts as a rising edge (IDLE → COUNT, `edge_pulse` asserted).

## Timing
- All outputs are registered; no combinational path from input to output.
- Edge latency: call the first `clk` edge that samples `sync_in`=1 edge 1.
  - `edge_pulse` is high during the cycle after edge 3 with the synchronizer, after edge 2 without it.
- `gap`, `gap_valid` and `viol` change in the same cycle as `edge_pulse`.
- `viol_cnt` updates one cycle after `viol`.
- Minimum observable spacing is 2 cycles (one low sample between highs).

## Configuration
- `SYNC_PULSE_CHECKER_2FF_EN` defined:
  - `sync_in` passes through a two-flop synchronizer, both flops reset to 0.
  - Edge latency is 3 edges.
- Not defined:
  - A single register samples `sync_in` directly.
  - Edge latency is 2 edges.
  - Intended for zero-delay RTL runs only.
- Spacing, violation and counter behaviour are identical in both builds.

## Structure
- Package `sync_pulse_checker_pkg` holds:
  - the FSM state enum typedef (IDLE, COUNT, SAT);
  - default constants for GAP_W, MIN_GAP and CNT_W.
- Sub-module `sync_2ff`: the two-flop synchronizer with synchronous active-high reset.
  - Instantiated only when the macro is defined.
- FSM, counters and output registers stay in the top module.

## Test plan
(GAP_W=8, MIN_GAP=4, CNT_W=16, macro defined)
- `rst` held 3 cycles, `sync_in`=0 → all outputs 0, FSM in IDLE; no strobes for 20 cycles after release.
- Single `sync_in` rise sampled at edge 1 → `edge_pulse` high one cycle after edge 3; `gap_valid`=0; `gap`=0.
- Two rises 10 cycles apart → second `edge_pulse` with `gap`=10, `gap_valid`=1, `viol`=0, `viol_cnt`=0.
- Two rises 3 cycles apart → `gap`=3, `viol`=1, `viol_cnt`=1 on the next cycle; repeat the pair → `viol_cnt`=2.
- Two rises 300 cycles apart → `gap`=255, `viol`=0; FSM in SAT before the second edge.
- `clear` with no violation → `viol_cnt`=0.
- `clear` in the same cycle as `viol` → `viol_cnt`=1.
- `rst` pulsed 5 cycles after an edge, then a new rise → `edge_pulse`=1 with `gap_valid`=0.
